sys_array_input_skew: RTL and testbench

Upstream feeder for `sys_array_basic`. Accepts one input vector of `ARRAY_L` elements per cycle over a valid/ready handshake. Drives `input_module` with the diagonal skew the array needs: lane j is delayed j cycles relative to lane 0. It inserts zero bubbles when upstream stalls, tags every lane with a skewed valid bit, and flushes the skew after the last vector, signalling completion.

---
 rtl/sys_array_pkg.sv | 16 +
 rtl/sys_array_input_skew_if.sv | 28 ++
 rtl/sys_array_input_skew_lane.sv | 46 ++++
 rtl/sys_array_input_skew.sv | 96 +++++++++
 tb/tb_sys_array_input_skew.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/sys_array_pkg.sv
// Shared types and helpers for the systolic array feeder blocks.
// Holds the skew FSM state encoding and the drain counter width helper.
package sys_array_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } skew_state_t;

    // Width for a counter that must reach n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sys_array_input_skew_if.sv
// Upstream vector handshake plus skewed array-side outputs of the input skew block.
// The master modport is the upstream/observer side; slave is the skew block itself.
interface sys_array_input_skew_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ARRAY_L    = 2,
    parameter int CNT_WIDTH  = 16
);
    logic                                   clear;
    logic                                   in_valid;
    logic                                   in_ready;
    logic                                   in_last;
    logic [0:ARRAY_L-1][DATA_WIDTH-1:0]     in_data;
    logic [0:ARRAY_L-1][DATA_WIDTH-1:0]     array_data;
    logic [0:ARRAY_L-1]                     array_valid;
    logic                                   busy;
    logic                                   done;
    logic [CNT_WIDTH-1:0]                   beat_count;

    modport master (
        output clear, in_valid, in_last, in_data,
        input  in_ready, array_data, array_valid, busy, done, beat_count
    );

    modport slave (
        input  clear, in_valid, in_last, in_data,
        output in_ready, array_data, array_valid, busy, done, beat_count
    );
endinterface

// File: rtl/sys_array_input_skew_lane.sv
// One skew lane: a DEPTH-stage {valid, data} shift register that advances every clock.
// Async active-low reset and synchronous clear both empty every stage.
module skew_lane #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data
);
    logic [DEPTH-1:0]      valid_reg;
    logic [DATA_WIDTH-1:0] data_reg  [DEPTH];
    logic [DEPTH-1:0]      valid_next;
    logic [DATA_WIDTH-1:0] data_next [DEPTH];

    always_comb begin
        valid_next[0] = in_valid;
        data_next[0]  = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            valid_next[i] = valid_reg[i-1];
            data_next[i]  = data_reg[i-1];
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : gen_stage
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                valid_reg[gi] <= 1'b0;
                data_reg[gi]  <= '0;
            end else if (clear) begin
                valid_reg[gi] <= 1'b0;
                data_reg[gi]  <= '0;
            end else begin
                valid_reg[gi] <= valid_next[gi];
                data_reg[gi]  <= data_next[gi];
            end
        end
    end

    assign out_valid = valid_reg[DEPTH-1];
    assign out_data  = data_reg[DEPTH-1];
endmodule

// File: rtl/sys_array_input_skew.sv
// Diagonal input skew for the systolic array: lane j delays its element j extra cycles,
// fills stalls with zero bubbles and drains the skew after the final vector.
module sys_array_input_skew
    import sys_array_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ARRAY_L    = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    sys_array_input_skew_if.slave  bus
);
    localparam int DCW = cnt_width(ARRAY_L);
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(ARRAY_L - 1);

    skew_state_t           state_reg, state_next;
    logic [DCW-1:0]        drain_cnt_reg, drain_cnt_next;
    logic [CNT_WIDTH-1:0]  beat_count_reg, beat_count_next;
    logic                  in_ready;
    logic                  accept;

    logic [0:ARRAY_L-1][DATA_WIDTH-1:0] lane_data;
    logic [0:ARRAY_L-1]                 lane_valid;

    // Ready depends on registered state only; a beat coinciding with clear is dropped.
    assign in_ready = (state_reg != DRAIN);
    assign accept   = bus.in_valid && in_ready && !bus.clear;

    always_comb begin
        state_next      = state_reg;
        drain_cnt_next  = '0;
        beat_count_next = beat_count_reg;
        if (bus.clear) begin
            state_next      = IDLE;
            beat_count_next = '0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (accept) begin
                        state_next      = bus.in_last ? DRAIN : STREAM;
                        beat_count_next = CNT_WIDTH'(1);
                    end
                end
                STREAM: begin
                    if (accept) begin
                        if (bus.in_last) state_next = DRAIN;
                        if (beat_count_reg != '1) beat_count_next = beat_count_reg + 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt_reg == DRAIN_LAST) begin
                        state_next = IDLE;
                    end else begin
                        drain_cnt_next = drain_cnt_reg + 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            drain_cnt_reg  <= '0;
            beat_count_reg <= '0;
        end else begin
            state_reg      <= state_next;
            drain_cnt_reg  <= drain_cnt_next;
            beat_count_reg <= beat_count_next;
        end
    end

    for (genvar gi = 0; gi < ARRAY_L; gi++) begin : gen_lane
        skew_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (gi + 1)
        ) u_lane (
            .clk       (clk),
            .reset_n   (reset_n),
            .clear     (bus.clear),
            .in_valid  (accept),
            .in_data   (accept ? bus.in_data[gi] : {DATA_WIDTH{1'b0}}),
            .out_valid (lane_valid[gi]),
            .out_data  (lane_data[gi])
        );
    end

    assign bus.in_ready    = in_ready;
    assign bus.array_data  = lane_data;
    assign bus.array_valid = lane_valid;
    assign bus.busy        = (state_reg != IDLE);
    assign bus.done        = (state_reg == DRAIN) && (drain_cnt_reg == DRAIN_LAST) && !bus.clear;
    assign bus.beat_count  = beat_count_reg;
endmodule

// File: tb/tb_sys_array_input_skew.sv
// Directed bench for the input skew block: a 2-lane and a 4-lane instance share clock and reset.
// Outputs are sampled 1 ns after each rising edge; inputs change at the same point.
module tb_sys_array_input_skew;
    logic clk;
    logic reset_n;
    int   n_assert;
    int   n_fail;

    sys_array_input_skew_if #(.DATA_WIDTH(8), .ARRAY_L(2), .CNT_WIDTH(16)) bus2 ();
    sys_array_input_skew_if #(.DATA_WIDTH(8), .ARRAY_L(4), .CNT_WIDTH(16)) bus4 ();

    sys_array_input_skew #(.DATA_WIDTH(8), .ARRAY_L(2), .CNT_WIDTH(16)) u_dut2 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus2)
    );

    sys_array_input_skew #(.DATA_WIDTH(8), .ARRAY_L(4), .CNT_WIDTH(16)) u_dut4 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hand-computed expectations, indexed by cycle after the first driven edge.
    int t2_l0 [1:8] = '{1, 3, 5, 7, 9, 0, 0, 0};
    int t2_l1 [1:8] = '{0, 2, 4, 6, 8, 10, 0, 0};
    int t3_in_v [1:8] = '{1, 1, 0, 0, 1, 1, 0, 0};
    int t3_e0 [1:8] = '{11, 13, 170, 170, 15, 17, 170, 170};
    int t3_e1 [1:8] = '{12, 14, 170, 170, 16, 18, 170, 170};
    int t3_l0 [1:8] = '{11, 13, 0, 0, 15, 17, 0, 0};
    int t3_l1 [1:8] = '{0, 12, 14, 0, 0, 16, 18, 0};
    int t3_bc [1:8] = '{1, 2, 2, 2, 3, 4, 4, 4};

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        bus2.clear = 1'b0; bus2.in_valid = 1'b0; bus2.in_last = 1'b0; bus2.in_data = '0;
        bus4.clear = 1'b0; bus4.in_valid = 1'b0; bus4.in_last = 1'b0; bus4.in_data = '0;

        // Reset then idle
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(bus2.in_ready), 1);
        chk("rst_valid", 32'(bus2.array_valid), 0);
        reset_n = 1'b1;
        tick();
        tick();
        chk("idle_ready", 32'(bus2.in_ready), 1);
        chk("idle_busy", 32'(bus2.busy), 0);
        chk("idle_done", 32'(bus2.done), 0);
        chk("idle_valid", 32'(bus2.array_valid), 0);
        chk("idle_data", 32'(bus2.array_data), 0);
        chk("idle_bc", 32'(bus2.beat_count), 0);
        chk("idle_ready4", 32'(bus4.in_ready), 1);
        $display("reset/idle step done");

        // Five-vector stream, last on the fifth
        for (int c = 1; c <= 8; c++) begin
            bus2.in_valid   = (c <= 5);
            bus2.in_last    = (c == 5);
            bus2.in_data[0] = (c <= 5) ? 8'(2 * c - 1) : 8'd0;
            bus2.in_data[1] = (c <= 5) ? 8'(2 * c) : 8'd0;
            tick();
            chk($sformatf("s_l0_d c%0d", c), 32'(bus2.array_data[0]), 32'(t2_l0[c]));
            chk($sformatf("s_l1_d c%0d", c), 32'(bus2.array_data[1]), 32'(t2_l1[c]));
            chk($sformatf("s_l0_v c%0d", c), 32'(bus2.array_valid[0]), 32'(t2_l0[c] != 0));
            chk($sformatf("s_l1_v c%0d", c), 32'(bus2.array_valid[1]), 32'(t2_l1[c] != 0));
            chk($sformatf("s_done c%0d", c), 32'(bus2.done), 32'(c == 6));
            chk($sformatf("s_ready c%0d", c), 32'(bus2.in_ready), 32'(!(c == 5 || c == 6)));
            chk($sformatf("s_busy c%0d", c), 32'(bus2.busy), 32'(c <= 6));
            chk($sformatf("s_bc c%0d", c), 32'(bus2.beat_count), 32'((c < 5) ? c : 5));
            $display("stream c=%0d lane0=%0d lane1=%0d done=%0b", c,
                     bus2.array_data[0], bus2.array_data[1], bus2.done);
        end

        // Two-cycle upstream gap mid-stream; garbage data on idle cycles must not leak
        for (int c = 1; c <= 8; c++) begin
            bus2.in_valid   = (t3_in_v[c] != 0);
            bus2.in_last    = (c == 6);
            bus2.in_data[0] = 8'(t3_e0[c]);
            bus2.in_data[1] = 8'(t3_e1[c]);
            tick();
            chk($sformatf("g_l0_d c%0d", c), 32'(bus2.array_data[0]), 32'(t3_l0[c]));
            chk($sformatf("g_l1_d c%0d", c), 32'(bus2.array_data[1]), 32'(t3_l1[c]));
            chk($sformatf("g_l0_v c%0d", c), 32'(bus2.array_valid[0]), 32'(t3_l0[c] != 0));
            chk($sformatf("g_l1_v c%0d", c), 32'(bus2.array_valid[1]), 32'(t3_l1[c] != 0));
            chk($sformatf("g_done c%0d", c), 32'(bus2.done), 32'(c == 7));
            chk($sformatf("g_ready c%0d", c), 32'(bus2.in_ready), 32'(!(c == 6 || c == 7)));
            chk($sformatf("g_bc c%0d", c), 32'(bus2.beat_count), 32'(t3_bc[c]));
            $display("gap c=%0d lane0=%0d lane1=%0d valid=%b", c,
                     bus2.array_data[0], bus2.array_data[1], bus2.array_valid);
        end
        bus2.in_data = '0;

        // Single-beat stream on the 4-lane instance
        bus4.in_valid = 1'b1;
        bus4.in_last  = 1'b1;
        bus4.in_data[0] = 8'd21; bus4.in_data[1] = 8'd22;
        bus4.in_data[2] = 8'd23; bus4.in_data[3] = 8'd24;
        for (int c = 1; c <= 5; c++) begin
            tick();
            bus4.in_valid = 1'b0;
            bus4.in_last  = 1'b0;
            bus4.in_data  = '0;
            for (int j = 0; j < 4; j++) begin
                chk($sformatf("w4_d c%0d j%0d", c, j), 32'(bus4.array_data[j]),
                    (j == c - 1) ? 32'(21 + j) : 32'd0);
                chk($sformatf("w4_v c%0d j%0d", c, j), 32'(bus4.array_valid[j]), 32'(j == c - 1));
            end
            chk($sformatf("w4_done c%0d", c), 32'(bus4.done), 32'(c == 4));
            chk($sformatf("w4_ready c%0d", c), 32'(bus4.in_ready), 32'(c == 5));
            chk($sformatf("w4_busy c%0d", c), 32'(bus4.busy), 32'(c <= 4));
            chk($sformatf("w4_bc c%0d", c), 32'(bus4.beat_count), 1);
            $display("wide c=%0d valid=%b done=%0b", c, bus4.array_valid, bus4.done);
        end

        // Clear while lane 1 still holds data; the beat presented with clear is dropped
        bus2.in_valid = 1'b1; bus2.in_last = 1'b0;
        bus2.in_data[0] = 8'd31; bus2.in_data[1] = 8'd32;
        tick();
        bus2.in_valid = 1'b0; bus2.in_data = '0;
        tick();
        chk("c_pre_l1_v", 32'(bus2.array_valid[1]), 1);
        chk("c_pre_l1_d", 32'(bus2.array_data[1]), 32);
        bus2.clear = 1'b1; bus2.in_valid = 1'b1; bus2.in_last = 1'b1;
        bus2.in_data[0] = 8'd35; bus2.in_data[1] = 8'd36;
        tick();
        bus2.clear = 1'b0; bus2.in_valid = 1'b0; bus2.in_last = 1'b0; bus2.in_data = '0;
        chk("c_valid", 32'(bus2.array_valid), 0);
        chk("c_data", 32'(bus2.array_data), 0);
        chk("c_done", 32'(bus2.done), 0);
        chk("c_bc", 32'(bus2.beat_count), 0);
        chk("c_ready", 32'(bus2.in_ready), 1);
        chk("c_busy", 32'(bus2.busy), 0);
        tick();
        chk("c_drop_valid", 32'(bus2.array_valid), 0);
        chk("c_drop_busy", 32'(bus2.busy), 0);
        $display("clear step valid=%b bc=%0d", bus2.array_valid, bus2.beat_count);

        // Async reset in the middle of DRAIN, between clock edges
        bus2.in_valid = 1'b1; bus2.in_last = 1'b1;
        bus2.in_data[0] = 8'd41; bus2.in_data[1] = 8'd42;
        tick();
        bus2.in_valid = 1'b0; bus2.in_last = 1'b0; bus2.in_data = '0;
        chk("r_pre_ready", 32'(bus2.in_ready), 0);
        chk("r_pre_l0_d", 32'(bus2.array_data[0]), 41);
        #3;
        reset_n = 1'b0;
        #1;
        chk("r_ready", 32'(bus2.in_ready), 1);
        chk("r_busy", 32'(bus2.busy), 0);
        chk("r_valid", 32'(bus2.array_valid), 0);
        chk("r_data", 32'(bus2.array_data), 0);
        chk("r_bc", 32'(bus2.beat_count), 0);
        #1;
        reset_n = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            tick();
            chk($sformatf("r_post_done c%0d", c), 32'(bus2.done), 0);
            chk($sformatf("r_post_valid c%0d", c), 32'(bus2.array_valid), 0);
            chk($sformatf("r_post_ready c%0d", c), 32'(bus2.in_ready), 1);
        end
        $display("async reset step done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
